// File: rtl/mem_initiator_pkg.sv
// mem_initiator_pkg
// Shared definitions for the byte-wide memory initiator: data/address widths,
// FSM state encoding and the odd-byte address helper.
package mem_initiator_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        StIdle   = 3'd0,
        StRdHi   = 3'd1,
        StRdLo   = 3'd2,
        StRdWait = 3'd3,
        StWrHi   = 3'd4,
        StWrLo   = 3'd5,
        StDone   = 3'd6
    } state_e;

    // Second byte of a word: force bit 0 high so the address never carries or wraps.
    function automatic logic [ADDR_W-1:0] odd_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:1], 1'b1};
    endfunction

endpackage

// File: rtl/mem_initiator_byte_assembler.sv
// mem_initiator_byte_assembler
// 16-bit read-data register built from two byte lanes with independent load enables.
// Ports:
//   clk, reset      - clock, asynchronous active-low clear
//   load_hi/load_lo - byte enables for the upper/lower lane
//   din_hi/din_lo   - byte data for each lane
//   dout            - assembled word {hi, lo}
module mem_initiator_byte_assembler
    import mem_initiator_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_hi,
    input  logic              load_lo,
    input  logic [BYTE_W-1:0] din_hi,
    input  logic [BYTE_W-1:0] din_lo,
    output logic [WORD_W-1:0] dout
);

    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [BYTE_W-1:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (load_hi) hi_d = din_hi;
        if (load_lo) lo_d = din_lo;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign dout = {hi_q, lo_q};

endmodule

// File: rtl/mem_initiator.sv
// mem_initiator
// Requesting end of a byte-addressed, big-endian word protocol. Each 16-bit
// request from the control unit becomes two byte transactions: high byte at the
// even address A, low byte at A|1.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   req/we/addr/wdata - word request (sampled only in idle)
//   rdata             - last word read
//   ack/err/busy      - completion pulse, misalignment flag, transaction in flight
//   mem_*             - byte memory port (read data returns the cycle after mem_rd)
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DW-1:0]     wdata,
    output logic [DW-1:0]     rdata,
    output logic              ack,
    output logic              err,
    output logic              busy,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [BYTE_W-1:0] mem_wdata,
    input  logic [BYTE_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [BYTE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BYTE_W-1:0] wr_lo_q, wr_lo_d;    // low write byte held until WR_LO
    logic [BYTE_W-1:0] rd_hi_q, rd_hi_d;    // high read byte held until the word is complete
    logic              err_q, err_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              load_word;

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wr_lo_d     = wr_lo_q;
        rd_hi_d     = rd_hi_q;
        err_d       = err_q;
        load_word   = 1'b0;

        case (state_q)
            StIdle: begin
                if (req) begin
                    err_d = 1'b0;
                    if (addr[0]) begin
                        // Misaligned: report without touching the memory port.
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else if (we) begin
                        state_d     = StWrHi;
                        mem_addr_d  = addr;
                        mem_wdata_d = wdata[DW-1:BYTE_W];
                        wr_lo_d     = wdata[BYTE_W-1:0];
                    end else begin
                        state_d    = StRdHi;
                        mem_addr_d = addr;
                    end
                end
            end
            StRdHi: begin
                state_d    = StRdLo;
                mem_addr_d = odd_addr(mem_addr_q);
            end
            StRdLo: begin
                state_d = StRdWait;
                rd_hi_d = mem_rdata;
            end
            StRdWait: begin
                // Both lanes load together so rdata never shows a half-updated word.
                state_d   = StDone;
                load_word = 1'b1;
            end
            StWrHi: begin
                state_d     = StWrLo;
                mem_addr_d  = odd_addr(mem_addr_q);
                mem_wdata_d = wr_lo_q;
            end
            StWrLo:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they are glitch-free.
        mem_rd_d = (state_d == StRdHi) || (state_d == StRdLo);
        mem_wr_d = (state_d == StWrHi) || (state_d == StWrLo);
        ack_d    = (state_d == StDone);
        busy_d   = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wr_lo_q     <= '0;
            rd_hi_q     <= '0;
            err_q       <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wr_lo_q     <= wr_lo_d;
            rd_hi_q     <= rd_hi_d;
            err_q       <= err_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
        end
    end

    mem_initiator_byte_assembler u_byte_assembler (
        .clk     (clk),
        .reset   (reset),
        .load_hi (load_word),
        .load_lo (load_word),
        .din_hi  (rd_hi_q),
        .din_lo  (mem_rdata),
        .dout    (rdata)
    );

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: doc/mem_initiator.md
# mem_initiator

Bus-side memory initiator between the CPU control unit and a byte-wide synchronous memory port. It accepts one 16-bit word request at a time from the control unit (MAR/MDR side) over a req/ack handshake. Each word is split into two big-endian byte transactions: high byte at the even address, low byte at address+1. It is the requesting end of the same byte-addressed, big-endian word protocol the memory model serves.

## Interface
Parameters:
- AW, 16, address width in bits
- DW, 16, word width in bits; fixed at two bytes

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset (reset=0 clears state)
- req  in  1  request from control unit; sampled only in IDLE
- we  in  1  1 = write word, 0 = read word; sampled with req
- addr  in  16  word byte-address; bit 0 must be 0
- wdata  in  16  write data; sampled with req
- rdata  out  16  last read word; reset 0
- ack  out  1  one-cycle completion pulse; reset 0
- err  out  1  misaligned-request flag, valid with ack; reset 0
- busy  out  1  high in every state except IDLE; reset 0
- mem_addr  out  16  byte address to memory; reset 0
- mem_rd  out  1  byte read strobe; reset 0
- mem_wr  out  1  byte write strobe; reset 0
- mem_wdata  out  8  byte write data; reset 0
- mem_rdata  in  8  byte read data; valid the cycle after mem_rd

## Operation
- FSM states: IDLE, RD_HI, RD_LO, RD_WAIT, WR_HI, WR_LO, DONE.
- On the acceptance edge (IDLE, req=1), addr, we and wdata are latched and err is cleared.
- IDLE transitions:
  - addr[0]=1 → DONE with err=1; no memory strobes are issued.
  - we=0 → RD_HI.
  - we=1 → WR_HI.
- Read sequence:
  - RD_HI: mem_rd=1, mem_addr=A.
  - RD_LO: mem_rd=1, mem_addr=A+1; the high byte is captured from mem_rdata.
  - RD_WAIT: the low byte is captured; rdata is loaded as {hi, lo} at the end of this state.
  - DONE.
- Write sequence:
  - WR_HI: mem_wr=1, mem_addr=A, mem_wdata=wdata[15:8].
  - WR_LO: mem_wr=1, mem_addr=A+1, mem_wdata=wdata[7:0].
  - DONE.
- DONE: ack=1 for exactly one cycle, then IDLE.
- mem_rd and mem_wr are never high together, and never high in IDLE or DONE.
- Addressing: A+1 is formed as {A[15:1],1'b1}, so it never wraps or carries. A=16'hFFFE uses bytes FFFE/FFFF.
- rdata holds its value across writes and misaligned requests.
- mem_addr and mem_wdata hold their last values when strobes are low.

## Timing
- Let E be the acceptance edge. ack is high in the cycle following:
  - E+3 for a read;
  - E+2 for a write;
  - E for a misaligned request.
- Read: rdata is valid when ack rises and stays stable until the next read completes.
- req is ignored while busy=1. A req held high through DONE is accepted in the IDLE cycle after DONE, so there is a minimum one-cycle gap between transactions.
- busy rises in the cycle after E and falls in the cycle after DONE.
- Reset assertion mid-transaction:
  - immediately forces IDLE and drives all outputs to their reset values;
  - mem_rd and mem_wr drop asynchronously;
  - no ack is issued;
  - a write aborted after WR_HI leaves only the high byte written. This is accepted behaviour; the control unit reissues the write.
- Reset deassertion: the first acceptance can occur on the first rising edge after reset goes high.

## Structure
- A shared package holds:
  - the FSM state encoding (3-bit localparams);
  - BYTE_W=8, WORD_W=16, ADDR_W=16;
  - the function forming the odd byte address.
- One sub-module, byte_assembler, is natural. It is a 16-bit register with load_hi and load_lo byte enables and asynchronous active-low clear, and it produces rdata.
- The FSM and output registers live in mem_initiator.

## Test plan
- Read 16'h0010, memory bytes [10]=8'hAB, [11]=8'hCD → mem_rd at 0010 then 0011, ack at E+3, rdata=16'hABCD, err=0.
- Write 16'h1234 to 16'h0020 → mem_wr with 0020/8'h12 then 0021/8'h34, ack at E+2, rdata unchanged; a readback returns 16'h1234.
- Misaligned read at 16'h0031 → ack at E with err=1, no mem_rd/mem_wr pulse, rdata unchanged; the next aligned request clears err.
- Boundary read at 16'hFFFE with bytes 8'h5A/8'hA5 → addresses FFFE then FFFF (no wrap to 0000), rdata=16'h5AA5.
- Back-to-back: req held high for two writes, plus a req pulse during WR_LO → second write accepted only in the IDLE after DONE, the pulse is ignored, and exactly two acks occur.
- Reset=0 asserted during RD_LO → all outputs 0 within the same cycle, no ack, busy=0; a fresh read after release completes normally.
